// File: rtl/slice_sequencer.sv
// slice_sequencer: issues one slice_enable per slice of a frame, tracks the
// pipelined write-back of each slice through a delay line, and flags
// frame_start requests that arrive while a frame is still in flight.
module slice_sequencer #(
  parameter int unsigned PIPE_DELAY = 3,
  parameter int unsigned ISSUE_GAP  = 1
) (
  input  logic       clock_200,
  input  logic       reset,
  input  logic       frame_start,
  input  logic [4:0] cfg_num_slices,
  input  logic [4:0] cfg_bank,
  input  logic [3:0] cfg_log_sel,
  input  logic       cfg_load,
  input  logic       overrun_clear,
  output logic       slice_enable,
  output logic [8:0] coefficient_read_adr,
  output logic [3:0] state_read_adr,
  output logic [3:0] state_write_adr,
  output logic       sigma_delta_storage_trigger,
  output logic [3:0] sigma_delta_storage_adr,
  output logic [3:0] log_address,
  output logic [4:0] active_bank,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int unsigned GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(ISSUE_GAP - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_q;
  logic [4:0]      pend_num_q;
  logic [4:0]      pend_bank_q;
  logic [3:0]      pend_log_q;
  logic [3:0]      act_last_q;
  logic [4:0]      act_bank_q;
  logic [3:0]      act_log_q;
  logic [3:0]      idx_q;
  logic [GW-1:0]   gap_q;
  logic            en_q;
  logic            done_q;
  logic            overrun_q;
  logic [3:0]      pend_last_d;

  logic [PIPE_DELAY-1:0] trig_q;
  logic [3:0]            wadr_q [PIPE_DELAY];

  // Last slice index of the pending frame; counts above 16 saturate at 16.
  always_comb begin
    pend_last_d = '0;
    if (pend_num_q[4]) pend_last_d = 4'd15;
    else               pend_last_d = pend_num_q[3:0] - 4'd1;
  end

  // Frame control FSM with config capture, issue pacing and overrun flag.
  always_ff @(posedge clock_200 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_num_q  <= '0;
      pend_bank_q <= '0;
      pend_log_q  <= '0;
      act_last_q  <= '0;
      act_bank_q  <= '0;
      act_log_q   <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (cfg_load) begin
        pend_num_q  <= cfg_num_slices;
        pend_bank_q <= cfg_bank;
        pend_log_q  <= cfg_log_sel;
      end
      if (frame_start && (state_q != IDLE)) overrun_q <= 1'b1;
      else if (overrun_clear)               overrun_q <= 1'b0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            act_last_q <= pend_last_d;
            act_bank_q <= pend_bank_q;
            act_log_q  <= pend_log_q;
            if (pend_num_q != '0) begin
              state_q <= ISSUE;
              en_q    <= 1'b1;
              idx_q   <= '0;
              gap_q   <= '0;
            end
          end
        end
        ISSUE: begin
          if (en_q && (idx_q == act_last_q)) begin
            state_q <= DRAIN;
          end else if (gap_q == GAP_LAST) begin
            en_q  <= 1'b1;
            idx_q <= idx_q + 4'd1;
            gap_q <= '0;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        DRAIN: begin
          // Final write-back: output stage fires with nothing behind it.
          if (trig_q[PIPE_DELAY-1] && ((trig_q << 1) == '0)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Delay line carrying each enable and its slice index to write-back.
  always_ff @(posedge clock_200 or posedge reset) begin
    if (reset) begin
      trig_q <= '0;
      for (int unsigned i = 0; i < PIPE_DELAY; i++) wadr_q[i] <= '0;
    end else begin
      trig_q[0] <= en_q;
      wadr_q[0] <= idx_q;
      for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
        trig_q[i] <= trig_q[i-1];
        wadr_q[i] <= wadr_q[i-1];
      end
    end
  end

  assign slice_enable                = en_q;
  assign coefficient_read_adr        = {act_bank_q, idx_q};
  assign state_read_adr              = idx_q;
  assign state_write_adr             = wadr_q[PIPE_DELAY-1];
  assign sigma_delta_storage_trigger = trig_q[PIPE_DELAY-1];
  assign sigma_delta_storage_adr     = wadr_q[PIPE_DELAY-1];
  assign log_address                 = act_log_q;
  assign active_bank                 = act_bank_q;
  assign busy                        = (state_q != IDLE);
  assign frame_done                  = done_q;
  assign overrun                     = overrun_q;

endmodule

// File: tb/tb_slice_sequencer.sv
// Directed bench for slice_sequencer: a default instance (PIPE_DELAY=3,
// ISSUE_GAP=1) and a second instance with ISSUE_GAP=2 for pacing checks.
module tb_slice_sequencer;

  logic       clock_200;
  logic       reset;
  logic       frame_start;
  logic       g_frame_start;
  logic [4:0] cfg_num_slices;
  logic [4:0] cfg_bank;
  logic [3:0] cfg_log_sel;
  logic       cfg_load;
  logic       overrun_clear;

  logic       slice_enable, sigma_delta_storage_trigger, busy, frame_done, overrun;
  logic [8:0] coefficient_read_adr;
  logic [3:0] state_read_adr, state_write_adr, sigma_delta_storage_adr, log_address;
  logic [4:0] active_bank;

  logic       g_slice_enable, g_trigger, g_busy, g_frame_done, g_overrun;
  logic [8:0] g_coef_adr;
  logic [3:0] g_rd_adr, g_wr_adr, g_sd_adr, g_log_address;
  logic [4:0] g_active_bank;

  int cmp_count = 0;
  int err_count = 0;

  slice_sequencer #(.PIPE_DELAY(3), .ISSUE_GAP(1)) dut (
    .clock_200(clock_200), .reset(reset), .frame_start(frame_start),
    .cfg_num_slices(cfg_num_slices), .cfg_bank(cfg_bank), .cfg_log_sel(cfg_log_sel),
    .cfg_load(cfg_load), .overrun_clear(overrun_clear),
    .slice_enable(slice_enable), .coefficient_read_adr(coefficient_read_adr),
    .state_read_adr(state_read_adr), .state_write_adr(state_write_adr),
    .sigma_delta_storage_trigger(sigma_delta_storage_trigger),
    .sigma_delta_storage_adr(sigma_delta_storage_adr), .log_address(log_address),
    .active_bank(active_bank), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  slice_sequencer #(.PIPE_DELAY(3), .ISSUE_GAP(2)) dut_gap (
    .clock_200(clock_200), .reset(reset), .frame_start(g_frame_start),
    .cfg_num_slices(cfg_num_slices), .cfg_bank(cfg_bank), .cfg_log_sel(cfg_log_sel),
    .cfg_load(cfg_load), .overrun_clear(overrun_clear),
    .slice_enable(g_slice_enable), .coefficient_read_adr(g_coef_adr),
    .state_read_adr(g_rd_adr), .state_write_adr(g_wr_adr),
    .sigma_delta_storage_trigger(g_trigger),
    .sigma_delta_storage_adr(g_sd_adr), .log_address(g_log_address),
    .active_bank(g_active_bank), .busy(g_busy), .frame_done(g_frame_done), .overrun(g_overrun)
  );

  initial clock_200 = 1'b0;
  always #5 clock_200 = ~clock_200;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock_200);
    #1;
  endtask

  task automatic load_cfg(input logic [4:0] n, input logic [4:0] b, input logic [3:0] l);
    cfg_num_slices = n;
    cfg_bank       = b;
    cfg_log_sel    = l;
    cfg_load       = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  // Starts a frame on the default instance and checks every cycle against the
  // hand-derived timeline: enables at k=0..n-1, triggers at k=3..n+2 carrying
  // index k-3, frame_done at k=n+3, busy through k=n+3. Optional strobes are
  // driven at cycle load_k / fs_k / clr_k (-1 = never).
  task automatic run_frame(input int n, input logic [4:0] bank,
                           input int load_k, input int fs_k, input int clr_k);
    logic [3:0] k4;
    logic [3:0] w4;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int k = 0; k < n + 8; k++) begin
      k4 = 4'(k);
      w4 = 4'(k - 3);
      check_eq("enable", slice_enable, (k < n));
      check_eq("busy", busy, (n > 0) && (k <= n + 3));
      check_eq("frame_done", frame_done, (n > 0) && (k == n + 3));
      check_eq("trigger", sigma_delta_storage_trigger, (k >= 3) && (k < n + 3));
      if (k < n) begin
        check_eq("state_read_adr", state_read_adr, k4);
        check_eq("coef_adr", coefficient_read_adr, {bank, k4});
      end
      if ((k >= 3) && (k < n + 3)) begin
        check_eq("state_write_adr", state_write_adr, w4);
        check_eq("sd_adr", sigma_delta_storage_adr, w4);
      end
      cfg_load      = (k == load_k);
      frame_start   = (k == fs_k);
      overrun_clear = (k == clr_k);
      step();
    end
    cfg_load      = 1'b0;
    frame_start   = 1'b0;
    overrun_clear = 1'b0;
  endtask

  task automatic clear_overrun();
    overrun_clear = 1'b1;
    step();
    overrun_clear = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    frame_start    = 1'b0;
    g_frame_start  = 1'b0;
    cfg_num_slices = '0;
    cfg_bank       = '0;
    cfg_log_sel    = '0;
    cfg_load       = 1'b0;
    overrun_clear  = 1'b0;
    #2;
    check_eq("rst_enable", slice_enable, 0);
    check_eq("rst_coef", coefficient_read_adr, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_trigger", sigma_delta_storage_trigger, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_bank", active_bank, 0);
    step();
    step();
    reset = 1'b0;
    step();

    // Basic 4-slice frame, bank 3, log channel 5.
    load_cfg(5'd4, 5'd3, 4'd5);
    run_frame(4, 5'd3, -1, -1, -1);
    check_eq("log_address", log_address, 5);
    check_eq("active_bank", active_bank, 3);

    // Mid-frame config load must not disturb the running frame.
    cfg_num_slices = 5'd2;
    cfg_bank       = 5'd7;
    cfg_log_sel    = 4'd9;
    run_frame(4, 5'd3, 1, -1, -1);
    check_eq("bank_hold", active_bank, 3);
    run_frame(2, 5'd7, -1, -1, -1);
    check_eq("bank_next", active_bank, 7);
    check_eq("log_next", log_address, 9);

    // Overrun: frame_start during ISSUE, no restart.
    check_eq("overrun_pre", overrun, 0);
    run_frame(2, 5'd7, -1, 1, -1);
    check_eq("overrun_set", overrun, 1);
    clear_overrun();
    check_eq("overrun_clr", overrun, 0);
    // Set wins over a simultaneous clear.
    run_frame(2, 5'd7, -1, 2, 2);
    check_eq("overrun_setwins", overrun, 1);
    clear_overrun();
    // frame_start in the DONE cycle also counts as overrun.
    run_frame(2, 5'd7, -1, 5, -1);
    check_eq("overrun_done", overrun, 1);
    clear_overrun();

    // Zero-slice frame: nothing pulses, active config still copied.
    load_cfg(5'd0, 5'd9, 4'd2);
    run_frame(0, 5'd9, -1, -1, -1);
    check_eq("n0_bank", active_bank, 9);
    check_eq("n0_log", log_address, 2);
    check_eq("n0_overrun", overrun, 0);

    // Count above 16 saturates to 16 slices, indices 0..15.
    load_cfg(5'd20, 5'd1, 4'd1);
    run_frame(16, 5'd1, -1, -1, -1);

    // ISSUE_GAP=2, two slices: enables at k=0,2; triggers at k=3,5; done k=6.
    load_cfg(5'd2, 5'd4, 4'd0);
    g_frame_start = 1'b1;
    step();
    g_frame_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check_eq("gap_enable", g_slice_enable, (k == 0) || (k == 2));
      check_eq("gap_trigger", g_trigger, (k == 3) || (k == 5));
      check_eq("gap_done", g_frame_done, (k == 6));
      check_eq("gap_busy", g_busy, (k <= 6));
      if (k == 2) check_eq("gap_coef", g_coef_adr, 9'h041);
      if (k == 3) check_eq("gap_wadr0", g_wr_adr, 0);
      if (k == 5) check_eq("gap_wadr1", g_wr_adr, 1);
      step();
    end

    // Reset on the 2nd enable of a 4-slice frame.
    load_cfg(5'd4, 5'd3, 4'd5);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    check_eq("pre_rst_enable", slice_enable, 1);
    check_eq("pre_rst_adr", state_read_adr, 1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_enable", slice_enable, 0);
    check_eq("mid_rst_coef", coefficient_read_adr, 0);
    check_eq("mid_rst_rdadr", state_read_adr, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_trigger", sigma_delta_storage_trigger, 0);
    check_eq("mid_rst_bank", active_bank, 0);
    check_eq("mid_rst_log", log_address, 0);
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_eq("post_rst_enable", slice_enable, 0);
      check_eq("post_rst_trigger", sigma_delta_storage_trigger, 0);
      check_eq("post_rst_done", frame_done, 0);
      check_eq("post_rst_busy", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

// File: doc/slice_sequencer.md
SLICE_SEQUENCER -- requirements
Module: slice_sequencer

Interface
REQ-001 Parameter PIPE_DELAY, default 3: cycles from slice_enable to that slice's state write-back and sigma-delta storage trigger.
REQ-002 Parameter ISSUE_GAP, default 1: cycles between successive slice_enable pulses (minimum 1).
REQ-003 clock_200  input  1  sole clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle strobe starting a frame of slice operations.
REQ-006 cfg_num_slices  input  5  slices per frame (0 = frame skipped; values >16 treated as 16).
REQ-007 cfg_bank  input  5  coefficient bank (coefficient address bits [8:4]).
REQ-008 cfg_log_sel  input  4  logging channel for log_address.
REQ-009 cfg_load  input  1  one-cycle strobe capturing cfg_* into pending registers.
REQ-010 overrun_clear  input  1  clears the overrun flag.
REQ-011 slice_enable  output  1  one-cycle enable per slice to the slice datapath.
REQ-012 coefficient_read_adr  output  9  {active_bank, slice index}.
REQ-013 state_read_adr  output  4  slice index, valid with slice_enable.
REQ-014 state_write_adr  output  4  slice index delayed PIPE_DELAY cycles.
REQ-015 sigma_delta_storage_trigger  output  1  slice_enable delayed PIPE_DELAY cycles.
REQ-016 sigma_delta_storage_adr  output  4  equals state_write_adr.
REQ-017 log_address  output  4  active logging channel.
REQ-018 active_bank  output  5  bank used by the current or last frame.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 frame_done  output  1  one-cycle pulse after the last write-back of a frame.
REQ-021 overrun  output  1  sticky; frame_start arrived while busy.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, DRAIN, DONE.
REQ-023 Pending config SHALL update on cfg_load in any state; the active config (num, bank, log_sel) SHALL copy from pending only on IDLE->ISSUE, so mid-frame cfg_load never affects the running frame.
REQ-024 IDLE: frame_start with pending num>0 -> ISSUE, index=0; frame_start with pending num=0 -> remain IDLE, no outputs pulse, active config still copied.
REQ-025 ISSUE: slice_enable SHALL pulse for one cycle every ISSUE_GAP cycles, first pulse in the first ISSUE cycle, index incrementing 0..num-1 with no skips or repeats.
REQ-026 coefficient_read_adr and state_read_adr SHALL be valid in the same cycle as slice_enable and hold their value between pulses.
REQ-027 After the pulse for index num-1: -> DRAIN.
REQ-028 DRAIN SHALL last until the final delayed sigma_delta_storage_trigger has asserted, then -> DONE.
REQ-029 DONE SHALL assert frame_done for exactly one cycle, then -> IDLE.
REQ-030 Delay line: sigma_delta_storage_trigger(t) = slice_enable(t-PIPE_DELAY), and state_write_adr(t) = state_read_adr sampled at that enable, for every slice including the last.
REQ-031 frame_start while busy SHALL be ignored (frame not restarted) and SHALL set overrun; if overrun_clear occurs in the same cycle, set wins.
REQ-032 frame_start in the DONE cycle SHALL count as overrun (busy is high).
REQ-033 Index counter SHALL be 4 bits; num=16 SHALL issue indices 0..15 without wrapping to a 17th slice.

Reset
REQ-034 Asserting reset SHALL immediately force IDLE, clear the delay line, and drive every output to 0; pending and active config and the overrun flag SHALL clear to 0.
REQ-035 Reset mid-frame SHALL abort the frame with no further slice_enable, trigger, or frame_done after deassertion.

Verification
REQ-036 cfg num=4, bank=3, load; frame_start -> slice_enable on 4 consecutive cycles, coefficient_read_adr 0x030..0x033, triggers 3 cycles later with adr 0..3, frame_done 1 cycle after last trigger.
REQ-037 ISSUE_GAP=2, num=2 -> enables 2 cycles apart; triggers at enable+3; busy low after frame_done.
REQ-038 Mid-frame cfg_load bank=7 -> current frame stays at bank 3; next frame uses 0x070 base.
REQ-039 frame_start during ISSUE -> overrun=1, no restart; overrun_clear with simultaneous frame_start -> overrun stays 1.
REQ-040 num=0 with frame_start -> no slice_enable, no frame_done, busy stays 0; num=16 -> exactly 16 enables, indices 0..15.
REQ-041 reset asserted on the 2nd enable of a 4-slice frame -> all outputs 0 immediately, no trigger or frame_done afterwards.
